// File: rtl/inc_dec_executor.sv
// inc_dec_executor
// Executes one 8-bit INC/DEC instruction per i_Start request. Register forms
// finish in a single execute cycle; the (HL) form performs a read-modify-write
// on the memory port, stalling on i_Mem_Ready. Opcodes that are not INC/DEC
// produce a one-cycle o_Illegal pulse with no side effects.
//
// Ports:
//   i_Clk, i_Reset_n         clock, asynchronous active-low reset
//   i_Start, i_Opcode        request and instruction byte (sampled in IDLE)
//   i_F, i_HL                current flags {Z,N,H,C} and HL address
//   o_Reg_Sel, i_Reg_Data    register read (combinational from o_Reg_Sel)
//   o_Reg_We, o_Reg_Wdata    register write-back
//   o_Mem_*, i_Mem_*         memory read/write, i_Mem_Ready completes an access
//   o_F, o_F_We              flag write-back
//   o_Busy, o_Done, o_Illegal  status; o_Done/o_Illegal are one-cycle pulses
module inc_dec_executor (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  input  logic [7:0]  i_Opcode,
  input  logic [3:0]  i_F,
  input  logic [15:0] i_HL,
  output logic [2:0]  o_Reg_Sel,
  input  logic [7:0]  i_Reg_Data,
  output logic        o_Reg_We,
  output logic [7:0]  o_Reg_Wdata,
  output logic [15:0] o_Mem_Addr,
  output logic        o_Mem_Rd,
  output logic        o_Mem_Wr,
  output logic [7:0]  o_Mem_Wdata,
  input  logic [7:0]  i_Mem_Rdata,
  input  logic        i_Mem_Ready,
  output logic [3:0]  o_F,
  output logic        o_F_We,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Illegal
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REG_EXEC  = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_ILLEGAL   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  opcode_r;
  logic [15:0] addr_r;
  logic [7:0]  data_r;

  // Only the register field and the INC/DEC bit are needed after decode, and
  // only the carry of the incoming flags survives an INC/DEC.
  logic [3:0] opcode_unused_s;
  logic [2:0] flags_unused_s;
  assign opcode_unused_s = {opcode_r[7:6], opcode_r[2:1]};
  assign flags_unused_s  = i_F[3:1];

  // INC r / DEC r family: 00 rrr 10d
  function automatic logic is_inc_dec(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[2:1] == 2'b10);
  endfunction

  function automatic logic [7:0] alu_result(input logic [7:0] x, input logic dec);
    return dec ? (x - 8'd1) : (x + 8'd1);
  endfunction

  // Flags {Z,N,H,C}; H flags the low-nibble borrow/carry, C passes through.
  function automatic logic [3:0] alu_flags(input logic [7:0] x, input logic dec,
                                           input logic c_in);
    logic [7:0] res;
    logic       half;
    res  = alu_result(x, dec);
    half = dec ? (x[3:0] == 4'h0) : (x[3:0] == 4'hF);
    return {(res == 8'h00), dec, half, c_in};
  endfunction

  // State register.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Opcode/address latch at start, memory byte capture on read completion.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      opcode_r <= 8'h00;
      addr_r   <= 16'h0000;
      data_r   <= 8'h00;
    end else begin
      if ((state_r == ST_IDLE) && i_Start) begin
        opcode_r <= i_Opcode;
        addr_r   <= i_HL;
      end
      if ((state_r == ST_MEM_READ) && i_Mem_Ready) begin
        data_r <= i_Mem_Rdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!i_Start) begin
          state_nxt_s = ST_IDLE;
        end else if (!is_inc_dec(i_Opcode)) begin
          state_nxt_s = ST_ILLEGAL;
        end else if (i_Opcode[5:3] == 3'd6) begin
          state_nxt_s = ST_MEM_READ;
        end else begin
          state_nxt_s = ST_REG_EXEC;
        end
      end
      ST_REG_EXEC:  state_nxt_s = ST_IDLE;
      ST_ILLEGAL:   state_nxt_s = ST_IDLE;
      ST_MEM_READ:  state_nxt_s = i_Mem_Ready ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_WRITE: state_nxt_s = i_Mem_Ready ? ST_IDLE : ST_MEM_WRITE;
      default:      state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs: decoded from state; data paths are combinational so the register
  // read and i_F of the write-back cycle feed the result directly.
  always_comb begin
    o_Reg_Sel   = 3'd0;
    o_Reg_We    = 1'b0;
    o_Reg_Wdata = 8'h00;
    o_Mem_Addr  = 16'h0000;
    o_Mem_Rd    = 1'b0;
    o_Mem_Wr    = 1'b0;
    o_Mem_Wdata = 8'h00;
    o_F         = 4'h0;
    o_F_We      = 1'b0;
    o_Busy      = 1'b0;
    o_Done      = 1'b0;
    o_Illegal   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        o_Busy = 1'b0;
      end
      ST_REG_EXEC: begin
        o_Busy      = 1'b1;
        o_Reg_Sel   = opcode_r[5:3];
        o_Reg_We    = 1'b1;
        o_Reg_Wdata = alu_result(i_Reg_Data, opcode_r[0]);
        o_F_We      = 1'b1;
        o_F         = alu_flags(i_Reg_Data, opcode_r[0], i_F[0]);
        o_Done      = 1'b1;
      end
      ST_MEM_READ: begin
        o_Busy     = 1'b1;
        o_Mem_Addr = addr_r;
        o_Mem_Rd   = 1'b1;
      end
      ST_MEM_WRITE: begin
        o_Busy      = 1'b1;
        o_Mem_Addr  = addr_r;
        o_Mem_Wr    = 1'b1;
        o_Mem_Wdata = alu_result(data_r, opcode_r[0]);
        if (i_Mem_Ready) begin
          o_F_We = 1'b1;
          o_F    = alu_flags(data_r, opcode_r[0], i_F[0]);
          o_Done = 1'b1;
        end else begin
          o_F_We = 1'b0;
          o_F    = 4'h0;
          o_Done = 1'b0;
        end
      end
      ST_ILLEGAL: begin
        o_Busy    = 1'b1;
        o_Illegal = 1'b1;
        o_Done    = 1'b1;
      end
      default: begin
        o_Busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_inc_dec_executor.sv
// Directed bench for inc_dec_executor: a table of register-form and illegal
// opcodes with hand-computed results, plus hand-written memory, busy and reset
// sequences. Outputs are packed into one vector and compared after the edge.
module tb_inc_dec_executor;

  logic        clk;
  logic        rst_n;
  logic        i_Start;
  logic [7:0]  i_Opcode;
  logic [3:0]  i_F;
  logic [15:0] i_HL;
  logic [2:0]  o_Reg_Sel;
  logic [7:0]  i_Reg_Data;
  logic        o_Reg_We;
  logic [7:0]  o_Reg_Wdata;
  logic [15:0] o_Mem_Addr;
  logic        o_Mem_Rd;
  logic        o_Mem_Wr;
  logic [7:0]  o_Mem_Wdata;
  logic [7:0]  i_Mem_Rdata;
  logic        i_Mem_Ready;
  logic [3:0]  o_F;
  logic        o_F_We;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Illegal;

  int checks = 0;
  int errors = 0;

  inc_dec_executor dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(i_Start), .i_Opcode(i_Opcode),
    .i_F(i_F), .i_HL(i_HL), .o_Reg_Sel(o_Reg_Sel), .i_Reg_Data(i_Reg_Data),
    .o_Reg_We(o_Reg_We), .o_Reg_Wdata(o_Reg_Wdata), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Rd(o_Mem_Rd), .o_Mem_Wr(o_Mem_Wr), .o_Mem_Wdata(o_Mem_Wdata),
    .i_Mem_Rdata(i_Mem_Rdata), .i_Mem_Ready(i_Mem_Ready), .o_F(o_F),
    .o_F_We(o_F_We), .o_Busy(o_Busy), .o_Done(o_Done), .o_Illegal(o_Illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] x;
    logic [3:0] f_in;
    logic       ill;
    logic [2:0] sel;
    logic [7:0] wd;
    logic [3:0] f_exp;
  } vec_t;

  vec_t vecs[13];

  // {busy,done,illegal,reg_we,f_we,rd,wr,sel,reg_wdata,f,mem_addr,mem_wdata}
  function automatic logic [45:0] pack(input logic busy, input logic done,
      input logic ill, input logic rwe, input logic fwe, input logic rd,
      input logic wr, input logic [2:0] sel, input logic [7:0] wd,
      input logic [3:0] f, input logic [15:0] addr, input logic [7:0] mwd);
    return {busy, done, ill, rwe, fwe, rd, wr, sel, wd, f, addr, mwd};
  endfunction

  function automatic logic [45:0] actual();
    return pack(o_Busy, o_Done, o_Illegal, o_Reg_We, o_F_We, o_Mem_Rd, o_Mem_Wr,
                o_Reg_Sel, o_Reg_Wdata, o_F, o_Mem_Addr, o_Mem_Wdata);
  endfunction

  task automatic chk(input string name, input logic [45:0] exp);
    logic [45:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (busy,done,ill,rwe,fwe,rd,wr,sel,wd,f,addr,mwd)",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one table entry, check the execute cycle, then the return to idle.
  task automatic run_vec(input vec_t v, input string name);
    i_Opcode   = v.op;
    i_Reg_Data = v.x;
    i_F        = v.f_in;
    i_Start    = 1'b1;
    tick();
    i_Start = 1'b0;
    #1;
    chk(name, pack(1'b1, 1'b1, v.ill, !v.ill, !v.ill, 1'b0, 1'b0,
                   v.sel, v.wd, v.f_exp, 16'h0000, 8'h00));
    tick();
    chk({name, "_idle"}, 46'd0);
  endtask

  initial begin
    // op, x, f_in, ill, sel, wd, f_exp
    vecs[0]  = '{8'h3C, 8'h0F, 4'h1, 1'b0, 3'd7, 8'h10, 4'h3};
    vecs[1]  = '{8'h05, 8'h01, 4'h0, 1'b0, 3'd0, 8'h00, 4'hC};
    vecs[2]  = '{8'h0C, 8'hFF, 4'h0, 1'b0, 3'd1, 8'h00, 4'hA};
    vecs[3]  = '{8'h15, 8'h00, 4'h1, 1'b0, 3'd2, 8'hFF, 4'h7};
    vecs[4]  = '{8'h1C, 8'h7F, 4'hF, 1'b0, 3'd3, 8'h80, 4'h3};
    vecs[5]  = '{8'h25, 8'h80, 4'h0, 1'b0, 3'd4, 8'h7F, 4'h6};
    vecs[6]  = '{8'h2C, 8'h41, 4'h8, 1'b0, 3'd5, 8'h42, 4'h0};
    vecs[7]  = '{8'h3D, 8'h10, 4'h1, 1'b0, 3'd7, 8'h0F, 4'h7};
    vecs[8]  = '{8'h00, 8'h12, 4'hF, 1'b1, 3'd0, 8'h00, 4'h0};
    vecs[9]  = '{8'h3E, 8'h12, 4'hF, 1'b1, 3'd0, 8'h00, 4'h0};
    vecs[10] = '{8'h76, 8'h12, 4'h1, 1'b1, 3'd0, 8'h00, 4'h0};
    vecs[11] = '{8'hC4, 8'h12, 4'h1, 1'b1, 3'd0, 8'h00, 4'h0};
    vecs[12] = '{8'h03, 8'h12, 4'h1, 1'b1, 3'd0, 8'h00, 4'h0};

    rst_n = 1'b0; i_Start = 1'b0; i_Opcode = 8'h00; i_F = 4'h0;
    i_HL = 16'h0000; i_Reg_Data = 8'h00; i_Mem_Rdata = 8'h00; i_Mem_Ready = 1'b0;
    #12;
    chk("reset_state", 46'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", 46'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_op%h", i, vecs[i].op));
    end

    // INC (HL) at 0xC000 holding 0xFF; read waits two cycles, write waits one.
    i_Opcode = 8'h34; i_HL = 16'hC000; i_F = 4'h0; i_Mem_Rdata = 8'hFF;
    i_Mem_Ready = 1'b0; i_Start = 1'b1;
    tick();
    i_Start = 1'b0; i_HL = 16'h1234; #1;
    chk("inc_hl_rd1", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'h0, 16'hC000, 8'h00));
    tick();
    chk("inc_hl_rd2", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'h0, 16'hC000, 8'h00));
    tick();
    i_Mem_Ready = 1'b1; #1;
    chk("inc_hl_rd3", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'h0, 16'hC000, 8'h00));
    tick();
    i_Mem_Ready = 1'b0; i_Mem_Rdata = 8'h55; #1;
    chk("inc_hl_wr_wait", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 4'h0, 16'hC000, 8'h00));
    tick();
    i_Mem_Ready = 1'b1; #1;
    chk("inc_hl_wr_done", pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 4'hA, 16'hC000, 8'h00));
    tick();
    chk("inc_hl_idle", 46'd0);

    // DEC (HL) holding 0x00 with memory always ready; a start during the
    // write cycle must be ignored.
    i_Opcode = 8'h35; i_HL = 16'h8001; i_F = 4'h0; i_Mem_Rdata = 8'h00;
    i_Mem_Ready = 1'b1; i_Start = 1'b1;
    tick();
    i_Start = 1'b0; #1;
    chk("dec_hl_rd", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'h0, 16'h8001, 8'h00));
    tick();
    i_Opcode = 8'h3C; i_Start = 1'b1; #1;
    chk("dec_hl_wr_done", pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 4'h6, 16'h8001, 8'hFF));
    tick();
    i_Start = 1'b0; #1;
    chk("busy_start_ignored_idle", 46'd0);
    tick();
    chk("busy_start_ignored_next", 46'd0);

    // Reset in the middle of a stalled write: everything drops at once.
    i_Opcode = 8'h34; i_HL = 16'hA5A5; i_Mem_Rdata = 8'h10; i_Mem_Ready = 1'b1;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    tick();
    i_Mem_Ready = 1'b0; #1;
    chk("pre_reset_wr", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 4'h0, 16'hA5A5, 8'h11));
    #2;
    rst_n = 1'b0; #1;
    chk("async_reset_outputs", 46'd0);
    i_Mem_Ready = 1'b1;
    tick();
    chk("reset_held_no_done", 46'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", 46'd0);
    run_vec(vecs[0], "inc_a_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
